// File: rtl/dot_seq.sv
// Dot-product sequencer driving an 8x8 signed MAC: bias load, operand streaming, two-cycle drain, capture.
// Define DOT_SEQ_SAT16_EN to clamp captured results to the signed 16-bit range and flag the clamp on res_sat.
module dot_seq #(
    parameter int LEN_W = 8
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             cmd_valid,
    output logic             cmd_ready,
    input  logic [LEN_W-1:0] cmd_len,
    input  logic [31:0]      cmd_bias,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [7:0]       in_x,
    input  logic [7:0]       in_y,
    output logic             mac_en,
    output logic             mac_acc_load,
    output logic [7:0]       mac_x,
    output logic [7:0]       mac_y,
    output logic [31:0]      mac_z,
    input  logic [31:0]      mac_result,
    output logic             res_valid,
    input  logic             res_ready,
    output logic [31:0]      res_data,
    output logic             res_sat
);

    typedef enum logic [2:0] {
        IDLE,
        LOAD,
        STREAM,
        DRAIN,
        CAPT,
        OUT
    } state_t;

    localparam logic [LEN_W-1:0] ONE = LEN_W'(1);

    state_t           state;
    state_t           state_nxt;
    logic [LEN_W-1:0] len_q;
    logic [LEN_W-1:0] cnt_q;
    logic [31:0]      bias_q;
    logic             drain_q;
    logic [31:0]      res_data_q;
    logic             res_sat_q;
    logic [31:0]      capt_data;
    logic             capt_sat;
    logic             last_pair;

    assign last_pair = (cnt_q == (len_q - ONE));

`ifdef DOT_SEQ_SAT16_EN
    always_comb begin
        capt_data = mac_result;
        capt_sat  = 1'b0;
        if ($signed(mac_result) > 32'sd32767) begin
            capt_data = 32'h0000_7FFF;
            capt_sat  = 1'b1;
        end else if ($signed(mac_result) < -32'sd32768) begin
            capt_data = 32'hFFFF_8000;
            capt_sat  = 1'b1;
        end
    end
`else
    assign capt_data = mac_result;
    assign capt_sat  = 1'b0;
`endif

    // drain_q selects between the two DRAIN cycles; result registers hold steady through OUT
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state      <= IDLE;
            len_q      <= '0;
            cnt_q      <= '0;
            bias_q     <= '0;
            drain_q    <= 1'b0;
            res_data_q <= '0;
            res_sat_q  <= 1'b0;
        end else begin
            state <= state_nxt;
            case (state)
                IDLE: begin
                    if (cmd_valid) begin
                        len_q  <= cmd_len;
                        bias_q <= cmd_bias;
                        cnt_q  <= '0;
                    end
                end
                STREAM: begin
                    if (in_valid) begin
                        cnt_q <= cnt_q + ONE;
                    end
                end
                DRAIN: begin
                    drain_q <= ~drain_q;
                end
                CAPT: begin
                    res_data_q <= capt_data;
                    res_sat_q  <= capt_sat;
                end
                default: begin
                end
            endcase
        end
    end

    // cmd_ready is masked by reset so nothing looks acceptable while rst_n is low
    assign cmd_ready = (state == IDLE) && rst_n;
    assign res_data  = res_data_q;
    assign res_sat   = res_sat_q;

    always_comb begin
        state_nxt    = state;
        in_ready     = 1'b0;
        mac_en       = 1'b0;
        mac_acc_load = 1'b0;
        mac_x        = 8'h00;
        mac_y        = 8'h00;
        mac_z        = 32'h0000_0000;
        res_valid    = 1'b0;
        case (state)
            IDLE: begin
                if (cmd_valid) begin
                    state_nxt = LOAD;
                end
            end
            LOAD: begin
                mac_en       = 1'b1;
                mac_acc_load = 1'b1;
                mac_z        = bias_q;
                state_nxt    = (len_q != '0) ? STREAM : DRAIN;
            end
            STREAM: begin
                in_ready = 1'b1;
                mac_en   = in_valid;
                mac_x    = in_x;
                mac_y    = in_y;
                if (in_valid && last_pair) begin
                    state_nxt = DRAIN;
                end
            end
            DRAIN: begin
                mac_en = 1'b1;
                if (drain_q) begin
                    state_nxt = CAPT;
                end
            end
            CAPT: begin
                state_nxt = OUT;
            end
            OUT: begin
                res_valid = 1'b1;
                if (res_ready) begin
                    state_nxt = IDLE;
                end
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

endmodule

// File: tb/tb_dot_seq.sv
// Bench for dot_seq: a behavioural two-stage 8x8 MAC closes the loop, and a queue of expected results
// is filled as each job is issued and drained when the sequencer presents its result.
module tb_dot_seq;

    localparam int LEN_W = 8;

    logic             clk = 1'b0;
    logic             rst_n = 1'b0;
    logic             cmd_valid = 1'b0;
    logic             cmd_ready;
    logic [LEN_W-1:0] cmd_len = '0;
    logic [31:0]      cmd_bias = '0;
    logic             in_valid = 1'b0;
    logic             in_ready;
    logic [7:0]       in_x = '0;
    logic [7:0]       in_y = '0;
    logic             mac_en;
    logic             mac_acc_load;
    logic [7:0]       mac_x;
    logic [7:0]       mac_y;
    logic [31:0]      mac_z;
    logic [31:0]      mac_result;
    logic             res_valid;
    logic             res_ready = 1'b0;
    logic [31:0]      res_data;
    logic             res_sat;

    int  checks = 0;
    int  fails = 0;
    byte xs[16];
    byte ys[16];
    int  expData[$];
    bit  expSat[$];

    always #5 clk = ~clk;

    dot_seq #(.LEN_W(LEN_W)) dut (
        .clk(clk), .rst_n(rst_n),
        .cmd_valid(cmd_valid), .cmd_ready(cmd_ready), .cmd_len(cmd_len), .cmd_bias(cmd_bias),
        .in_valid(in_valid), .in_ready(in_ready), .in_x(in_x), .in_y(in_y),
        .mac_en(mac_en), .mac_acc_load(mac_acc_load), .mac_x(mac_x), .mac_y(mac_y), .mac_z(mac_z),
        .mac_result(mac_result),
        .res_valid(res_valid), .res_ready(res_ready), .res_data(res_data), .res_sat(res_sat)
    );

    // Behavioural MAC: product stage 1, product stage 2, then accumulate; load flushes both products
    logic signed [31:0] macAcc;
    logic signed [15:0] prod1;
    logic signed [15:0] prod2;

    always @(posedge clk) begin
        if (!rst_n) begin
            macAcc <= '0;
            prod1  <= '0;
            prod2  <= '0;
        end else if (mac_en) begin
            if (mac_acc_load) begin
                macAcc <= mac_z;
                prod1  <= '0;
                prod2  <= '0;
            end else begin
                prod1  <= $signed(mac_x) * $signed(mac_y);
                prod2  <= prod1;
                macAcc <= macAcc + 32'(prod2);
            end
        end
    end

    assign mac_result = macAcc;

    task automatic checkOutput(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        if (obs !== exp) begin
            fails++;
            $display("[TB] FAIL %s: got %0d (0x%08h) expected %0d (0x%08h)",
                     tag, $signed(obs), obs, $signed(exp), exp);
        end
    endtask

    // Called #1 after an edge; returns #1 after the command handshake edge (DUT then in LOAD)
    task automatic sendCommand(input int len, input int bias);
        int waitCyc = 0;
        cmd_valid = 1'b1;
        cmd_len   = LEN_W'(len);
        cmd_bias  = bias;
        while (!cmd_ready && waitCyc < 50) begin
            @(posedge clk); #1;
            waitCyc++;
        end
        checkOutput("cmd_accept", {31'd0, cmd_ready}, 32'd1);
        @(posedge clk); #1;
        cmd_valid = 1'b0;
    endtask

    task automatic applyStimulus(input int len, input int bias, input int gap, input int holdOff);
        int acc = bias;
        bit sat = 1'b0;
        int cyc;
        int pairIdx = 0;
        int gapCnt = gap;
        int enCnt = 0;
        int rdyCnt = 0;
        int cmdRdyCnt = 0;
        int gapTotal;
        int expD;
        bit expS;
        for (int i = 0; i < len; i++) begin
            acc = acc + int'(xs[i]) * int'(ys[i]);
        end
`ifdef DOT_SEQ_SAT16_EN
        if (acc > 32767) begin
            acc = 32767;
            sat = 1'b1;
        end else if (acc < -32768) begin
            acc = -32768;
            sat = 1'b1;
        end
`endif
        expData.push_back(acc);
        expSat.push_back(sat);
        gapTotal = (len > 0) ? gap * (len - 1) : 0;

        sendCommand(len, bias);
        checkOutput("load_acc_load", {31'd0, mac_acc_load}, 32'd1);
        checkOutput("load_mac_z", mac_z, bias);

        cyc = 1;
        while (!res_valid && cyc < 300) begin
            if (in_ready) begin
                rdyCnt++;
                if (gapCnt < gap) begin
                    in_valid = 1'b0;
                    gapCnt++;
                end else if (pairIdx < len) begin
                    in_valid = 1'b1;
                    in_x     = xs[pairIdx];
                    in_y     = ys[pairIdx];
                    pairIdx++;
                    gapCnt   = 0;
                end else begin
                    in_valid = 1'b0;
                end
            end else begin
                in_valid = 1'b0;
            end
            #1;
            if (mac_en) enCnt++;
            if (cmd_ready) cmdRdyCnt++;
            @(posedge clk); #1;
            cyc++;
        end
        in_valid = 1'b0;
        checkOutput("res_valid_cycle", cyc, len + 5 + gapTotal);
        checkOutput("mac_en_cycles", enCnt, len + 3);
        checkOutput("in_ready_cycles", rdyCnt, len + gapTotal);
        checkOutput("cmd_ready_busy", cmdRdyCnt, 0);

        for (int h = 0; h < holdOff; h++) begin
            res_ready = 1'b0;
            checkOutput("hold_valid", {31'd0, res_valid}, 32'd1);
            checkOutput("hold_data", res_data, acc);
            checkOutput("hold_readies", {30'd0, cmd_ready, in_ready}, 32'd0);
            @(posedge clk); #1;
        end

        res_ready = 1'b1;
        expD = expData.pop_front();
        expS = expSat.pop_front();
        checkOutput("res_data", res_data, expD);
        checkOutput("res_sat", {31'd0, res_sat}, {31'd0, expS});
        @(posedge clk); #1;
        res_ready = 1'b0;
        checkOutput("back_to_idle", {30'd0, res_valid, cmd_ready}, 32'd1);
    endtask

    initial begin
        repeat (3) @(posedge clk);
        #1;
        checkOutput("reset_outputs",
                    {26'd0, cmd_ready, in_ready, mac_en, mac_acc_load, res_valid, res_sat}, 32'd0);
        checkOutput("reset_res_data", res_data, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("idle_cmd_ready", {31'd0, cmd_ready}, 32'd1);

        xs[0] = 1;  ys[0] = 2;
        xs[1] = 3;  ys[1] = 4;
        xs[2] = -5; ys[2] = 6;
        applyStimulus(3, 10, 0, 0);

        applyStimulus(0, -7, 0, 0);

        xs[0] = -128; ys[0] = -128;
        xs[1] = 127;  ys[1] = 127;
        applyStimulus(2, 0, 3, 0);

        xs[0] = 2;  ys[0] = 3;
        xs[1] = -4; ys[1] = 5;
        applyStimulus(2, 100, 0, 5);

        // Abort a len=4 job mid-stream, then check the next job sees no leftover product
        xs[0] = 7; ys[0] = 7;
        xs[1] = 9; ys[1] = 9;
        sendCommand(4, 1000);
        @(posedge clk); #1;
        for (int i = 0; i < 2; i++) begin
            in_valid = 1'b1;
            in_x     = xs[i];
            in_y     = ys[i];
            @(posedge clk); #1;
        end
        checkOutput("abort_in_stream", {31'd0, in_ready}, 32'd1);
        in_x  = 8'd11;
        in_y  = 8'd11;
        rst_n = 1'b0;
        @(posedge clk); #1;
        in_valid = 1'b0;
        checkOutput("abort_reset_outputs",
                    {28'd0, cmd_ready, in_ready, mac_en, res_valid}, 32'd0);
        rst_n = 1'b1;
        @(posedge clk); #1;
        checkOutput("abort_idle", {30'd0, cmd_ready, res_valid}, 32'd2);
        xs[0] = 3; ys[0] = 3;
        applyStimulus(1, 5, 0, 0);

        xs[0] = 1; ys[0] = 1;
        applyStimulus(1, 32767, 0, 0);
        applyStimulus(1, 32'h7FFF_FFFF, 0, 1);

        for (int j = 0; j < 4; j++) begin
            int len = int'($urandom_range(1, 6));
            for (int i = 0; i < len; i++) begin
                xs[i] = byte'($urandom);
                ys[i] = byte'($urandom);
            end
            applyStimulus(len, int'($urandom_range(0, 40000)) - 20000,
                          int'($urandom_range(0, 2)), int'($urandom_range(0, 2)));
        end

        $display("%0d/%0d checks passed", checks - fails, checks);
        $finish;
    end

endmodule
